// File: rtl/numberle_round_ctrl_if.sv
// Port bundle of the Numberle round sequencer: keypad, raw buttons and secret in,
// guess/cursor/score/display state out.
interface numberle_round_ctrl_if;
  logic [3:0]  key_val;
  logic        btn_right;
  logic        btn_left;
  logic        btn_submit;
  logic [15:0] secret;
  logic        secret_valid;
  logic [15:0] guess;
  logic [1:0]  cursor;
  logic [7:0]  feedback;
  logic [3:0]  try_count;
  logic [1:0]  disp_mode;
  logic [15:0] led;

  modport master (
    output key_val, btn_right, btn_left, btn_submit, secret, secret_valid,
    input  guess, cursor, feedback, try_count, disp_mode, led
  );

  modport slave (
    input  key_val, btn_right, btn_left, btn_submit, secret, secret_valid,
    output guess, cursor, feedback, try_count, disp_mode, led
  );
endinterface

// File: rtl/numberle_round_ctrl.sv
// Numberle round sequencer: guess editing, two-pass scoring against the secret, display mode.
// Optional macro NUMBERLE_HINT_LED_EN mirrors feedback/try count/lose onto the LEDs.
module numberle_round_ctrl #(
  parameter int MAX_TRIES       = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SHOW_CYCLES     = 50000000
) (
  input  logic                  clock,
  input  logic                  reset,
  numberle_round_ctrl_if.slave  io_if
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SH_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SH_W-1:0] SH_LAST   = SH_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]      TRY_LIMIT = 4'(MAX_TRIES);
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_SUB   = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHK_EXACT, S_CHK_PRESENT, S_SHOW, S_WIN, S_LOSE
  } state_t;

  logic [2:0]      w_btn_raw;
  logic [2:0]      r_sync1, r_sync2, r_db, r_db_q;
  logic [DB_W-1:0] r_db_cnt [3];
  logic [2:0]      w_pulse;
  logic [3:0]      r_key1, r_key2;
  logic            w_key_evt;

  state_t          r_state;
  logic [15:0]     r_guess;
  logic [1:0]      r_cursor;
  logic [7:0]      r_fb;
  logic [3:0]      r_try;
  logic [1:0]      r_mode;
  logic [3:0]      r_exact, r_used;
  logic [1:0]      r_idx;
  logic [SH_W-1:0] r_show_cnt;

  logic [3:0]      w_exact;
  logic [7:0]      w_fb_exact;
  logic            w_full;
  logic [3:0]      w_gi;
  logic            w_found, w_hit;
  logic [1:0]      w_j;
  logic [3:0]      w_try_nxt;
  logic [15:0]     w_led;

  assign w_btn_raw = {io_if.btn_submit, io_if.btn_left, io_if.btn_right};

  // Button conditioning: 2-FF synchroniser, then level accepted after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int b = 0; b < 3; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int b = 0; b < 3; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_db_cnt[b] <= '0;
          r_db[b]     <= r_sync2[b];
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_pulse = r_db & ~r_db_q;

  // Keypad sampling: an event only on the F -> digit transition, so a held key counts once
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key1 <= 4'hF;
      r_key2 <= 4'hF;
    end else begin
      r_key1 <= io_if.key_val;
      r_key2 <= r_key1;
    end
  end

  assign w_key_evt = (r_key2 == 4'hF) && (r_key1 <= 4'd9);

  always_comb begin
    w_full     = 1'b1;
    w_exact    = '0;
    w_fb_exact = '0;
    for (int i = 0; i < 4; i++) begin
      w_exact[i]            = (r_guess[4*i +: 4] == io_if.secret[4*i +: 4]);
      w_fb_exact[2*i +: 2]  = w_exact[i] ? 2'b10 : 2'b00;
      if (r_guess[4*i +: 4] == 4'hF) w_full = 1'b0;
    end
  end

  // Lowest unused secret position matching the digit under test; descending loop keeps the lowest
  always_comb begin
    w_gi    = r_guess[{r_idx, 2'b00} +: 4];
    w_found = 1'b0;
    w_j     = '0;
    for (int j = 3; j >= 0; j--) begin
      if (!r_used[j] && (io_if.secret[4*j +: 4] == w_gi)) begin
        w_found = 1'b1;
        w_j     = 2'(j);
      end
    end
    w_hit = w_found && !r_exact[r_idx];
  end

  assign w_try_nxt = (r_try == 4'hF) ? 4'hF : r_try + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_guess    <= 16'hFFFF;
      r_cursor   <= '0;
      r_fb       <= '0;
      r_try      <= '0;
      r_mode     <= '0;
      r_exact    <= '0;
      r_used     <= '0;
      r_idx      <= '0;
      r_show_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_guess  <= 16'hFFFF;
          r_cursor <= '0;
          r_fb     <= '0;
          r_try    <= '0;
          r_mode   <= 2'd0;
          if (io_if.secret_valid) r_state <= S_ENTRY;
        end
        S_ENTRY: begin
          if (w_pulse[B_SUB] && w_full) begin
            r_state <= S_CHK_EXACT;
          end else begin
            if (w_key_evt) r_guess[{r_cursor, 2'b00} +: 4] <= r_key1;
            if (w_pulse[B_RIGHT] && !w_pulse[B_LEFT])      r_cursor <= r_cursor + 2'd1;
            else if (w_pulse[B_LEFT] && !w_pulse[B_RIGHT]) r_cursor <= r_cursor - 2'd1;
          end
        end
        S_CHK_EXACT: begin
          r_exact <= w_exact;
          r_used  <= w_exact;
          r_fb    <= w_fb_exact;
          r_idx   <= '0;
          r_state <= S_CHK_PRESENT;
        end
        S_CHK_PRESENT: begin
          if (w_hit) begin
            r_fb[{r_idx, 1'b0} +: 2] <= 2'b01;
            r_used[w_j]              <= 1'b1;
          end
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_try <= w_try_nxt;
            if (r_exact == 4'hF) begin
              r_state <= S_WIN;
              r_mode  <= 2'd2;
            end else if (w_try_nxt == TRY_LIMIT) begin
              r_state <= S_LOSE;
              r_mode  <= 2'd3;
            end else begin
              r_state    <= S_SHOW;
              r_mode     <= 2'd1;
              r_show_cnt <= '0;
            end
          end
        end
        S_SHOW: begin
          if (r_show_cnt == SH_LAST) begin
            r_state  <= S_ENTRY;
            r_guess  <= 16'hFFFF;
            r_cursor <= '0;
            r_mode   <= 2'd0;
          end else begin
            r_show_cnt <= r_show_cnt + 1'b1;
          end
        end
        S_WIN, S_LOSE: begin
          if (w_pulse[B_SUB]) begin
            r_state  <= S_IDLE;
            r_try    <= '0;
            r_guess  <= 16'hFFFF;
            r_fb     <= '0;
            r_cursor <= '0;
            r_mode   <= 2'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NUMBERLE_HINT_LED_EN
  assign w_led = {r_state == S_WIN, r_state == S_LOSE, 2'b00, r_try, r_fb};
`else
  assign w_led = {r_state == S_WIN, 15'd0};
`endif

  assign io_if.guess     = r_guess;
  assign io_if.cursor    = r_cursor;
  assign io_if.feedback  = r_fb;
  assign io_if.try_count = r_try;
  assign io_if.disp_mode = r_mode;
  assign io_if.led       = w_led;
endmodule

// File: tb/tb_numberle_round_ctrl.sv
// Randomised self-checking bench for numberle_round_ctrl against a count-based scoring model.
module tb_numberle_round_ctrl;
  localparam int DEB   = 4;
  localparam int SHOW  = 8;
  localparam int TRIES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  numberle_round_ctrl_if bus ();

  numberle_round_ctrl #(
    .MAX_TRIES(TRIES), .DEBOUNCE_CYCLES(DEB), .SHOW_CYCLES(SHOW)
  ) dut (
    .clock(clk), .reset(rst), .io_if(bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_guess = 16'hFFFF;
  logic [1:0]  m_cursor = 2'd0;
  int          m_try = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference scoring: exact matches first, then credit misplaced digits from the leftover counts
  function automatic logic [7:0] score(input logic [15:0] g, input logic [15:0] s);
    int         left_cnt [16];
    logic [7:0] fb;
    logic [3:0] gd, sd;
    fb = '0;
    for (int d = 0; d < 16; d++) left_cnt[d] = 0;
    for (int i = 0; i < 4; i++) begin
      gd = g[4*i +: 4];
      sd = s[4*i +: 4];
      if (gd == sd) fb[2*i +: 2] = 2'b10;
      else left_cnt[sd]++;
    end
    for (int i = 0; i < 4; i++) begin
      gd = g[4*i +: 4];
      if (fb[2*i +: 2] != 2'b10 && left_cnt[gd] > 0) begin
        fb[2*i +: 2] = 2'b01;
        left_cnt[gd]--;
      end
    end
    return fb;
  endfunction

  function automatic logic [15:0] exp_led(input int mode, input logic [7:0] fb, input int t);
`ifdef NUMBERLE_HINT_LED_EN
    return {mode == 2, mode == 3, 2'b00, 4'(t), fb};
`else
    return {mode == 2, 15'd0};
`endif
  endfunction

  task automatic key(input logic [3:0] d);
    bus.key_val = d;
    cyc(3);
    bus.key_val = 4'hF;
    cyc(3);
    m_guess[int'(m_cursor)*4 +: 4] = d;
  endtask

  task automatic press(input bit r, input bit l);
    bus.btn_right = r;
    bus.btn_left  = l;
    cyc(DEB + 4);
    bus.btn_right = 1'b0;
    bus.btn_left  = 1'b0;
    cyc(DEB + 4);
    if (r && !l) m_cursor = m_cursor + 2'd1;
    else if (l && !r) m_cursor = m_cursor - 2'd1;
  endtask

  task automatic enter_guess(input logic [15:0] g);
    for (int i = 0; i < 4; i++) begin
      key(g[4*i +: 4]);
      press(1'b1, 1'b0);
    end
    check("guess_entry", bus.guess, m_guess);
  endtask

  task automatic submit_scored(output int mode);
    logic [7:0] fb;
    bus.btn_submit = 1'b1;
    cyc(DEB + 7);
    check("latency_pre", bus.disp_mode, 0);
    cyc(1);
    fb    = score(m_guess, bus.secret);
    m_try = (m_try < 15) ? m_try + 1 : 15;
    mode  = (fb == 8'hAA) ? 2 : (m_try == TRIES) ? 3 : 1;
    check("feedback", bus.feedback, fb);
    check("try_count", bus.try_count, m_try);
    check("disp_mode", bus.disp_mode, mode);
    check("led", bus.led, exp_led(mode, fb, m_try));
    bus.btn_submit = 1'b0;
    if (mode == 1) begin
      cyc(SHOW - 1);
      check("show_hold", bus.disp_mode, 1);
      cyc(1);
      m_guess  = 16'hFFFF;
      m_cursor = 2'd0;
      check("show_end_mode", bus.disp_mode, 0);
      check("show_end_guess", bus.guess, m_guess);
      check("show_end_cursor", bus.cursor, m_cursor);
      cyc(4);
    end else begin
      cyc(DEB + 6);
    end
  endtask

  task automatic restart();
    bus.btn_submit = 1'b1;
    cyc(DEB + 5);
    m_try = 0; m_guess = 16'hFFFF; m_cursor = 2'd0;
    check("restart_try", bus.try_count, m_try);
    check("restart_guess", bus.guess, m_guess);
    check("restart_fb", bus.feedback, 0);
    check("restart_mode", bus.disp_mode, 0);
    bus.btn_submit = 1'b0;
    cyc(DEB + 6);
  endtask

  function automatic logic [15:0] rand_guess(input int maxd);
    logic [15:0] g;
    for (int i = 0; i < 4; i++) g[4*i +: 4] = 4'($urandom_range(0, maxd));
    return g;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    logic [15:0] g;
    bus.key_val = 4'hF; bus.btn_right = 0; bus.btn_left = 0; bus.btn_submit = 0;
    bus.secret = 16'h0000; bus.secret_valid = 1'b0;
    rst = 1'b1;
    cyc(3);
    check("rst_guess", bus.guess, 16'hFFFF);
    check("rst_cursor", bus.cursor, 0);
    check("rst_fb", bus.feedback, 0);
    check("rst_try", bus.try_count, 0);
    check("rst_mode", bus.disp_mode, 0);
    check("rst_led", bus.led, 0);
    rst = 1'b0;
    cyc(2);
    bus.key_val = 4'd7; cyc(3); bus.key_val = 4'hF; cyc(3);
    check("idle_ignores_key", bus.guess, 16'hFFFF);

    // Straight win
    bus.secret = 16'h4321; bus.secret_valid = 1'b1;
    cyc(2);
    enter_guess(16'h4321);
    submit_scored(mode);
    check("win_mode", mode, 2);
    restart();

    // Incomplete guess is ignored, then duplicate-digit scoring
    bus.secret = 16'h1123;
    key(4'd1); press(1, 0); key(4'd1); press(1, 0); press(1, 0); key(4'd5); press(1, 0);
    check("partial_guess", bus.guess, m_guess);
    bus.btn_submit = 1'b1; cyc(DEB + 10);
    check("partial_try", bus.try_count, 0);
    check("partial_mode", bus.disp_mode, 0);
    check("partial_keep", bus.guess, m_guess);
    bus.btn_submit = 1'b0; cyc(DEB + 6);
    press(1, 0); press(1, 0); key(4'd1); press(1, 0); press(1, 0);
    check("dup_guess", bus.guess, m_guess);
    submit_scored(mode);
    enter_guess(16'h9999);
    submit_scored(mode);
    enter_guess(16'h8888);
    submit_scored(mode);
    check("lose_mode", mode, 3);
    restart();

    // Cursor wrap, cancel and bounce rejection
    press(0, 1);
    check("cursor_left_wrap", bus.cursor, m_cursor);
    press(1, 1);
    check("cursor_cancel", bus.cursor, m_cursor);
    press(1, 0);
    check("cursor_right_wrap", bus.cursor, m_cursor);
    bus.btn_right = 1'b1; cyc(DEB - 1); bus.btn_right = 1'b0; cyc(DEB + 6);
    check("cursor_bounce", bus.cursor, m_cursor);

    // Random rounds
    for (int r = 0; r < 5; r++) begin
      bus.secret = rand_guess((r % 2 == 0) ? 3 : 9);
      for (int t = 0; t < TRIES; t++) begin
        g = ($urandom_range(0, 3) == 0) ? bus.secret : rand_guess(4);
        enter_guess(g);
        submit_scored(mode);
        if (mode >= 2) break;
      end
      restart();
    end

    // Reset during the present-search pass
    enter_guess(16'h0123);
    bus.btn_submit = 1'b1;
    cyc(DEB + 5);
    rst = 1'b1; bus.btn_submit = 1'b0; bus.secret_valid = 1'b0;
    cyc(1);
    check("midrst_guess", bus.guess, 16'hFFFF);
    check("midrst_cursor", bus.cursor, 0);
    check("midrst_fb", bus.feedback, 0);
    check("midrst_try", bus.try_count, 0);
    check("midrst_mode", bus.disp_mode, 0);
    check("midrst_led", bus.led, 0);
    rst = 1'b0;
    cyc(2);
    bus.key_val = 4'd6; cyc(3); bus.key_val = 4'hF; cyc(8);
    check("midrst_idle", bus.guess, 16'hFFFF);
    check("midrst_idle_try", bus.try_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
